// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and address map for the M-stage load/store unit.
// The optional bus watchdog in mem_lsu is enabled by defining LSU_TIMEOUT_EN.
package mem_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LW   = 4'd1,
    OP_LH   = 4'd2,
    OP_LHU  = 4'd3,
    OP_LB   = 4'd4,
    OP_LBU  = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_ADES = 5'd5;
  localparam logic [4:0]  EXC_DBE  = 5'd7;

  localparam logic [31:0] DM_TOP   = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
  localparam logic [31:0] IG_BASE  = 32'h0000_7F20;
  localparam logic [31:0] TC0_CNT  = TC0_BASE + 32'd8;
  localparam logic [31:0] TC1_CNT  = TC1_BASE + 32'd8;

  localparam logic [4:0]  TIMEOUT_CYCLES = 5'd16;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SW) && (op <= OP_SB);
  endfunction

  // Address/alignment/permission check; 1 means the access must raise AdEL/AdES.
  function automatic logic addr_fault(input logic [3:0] op, input logic [31:0] a);
    logic word_op;
    logic half_op;
    logic in_dm;
    logic in_tc;
    logic in_ig;
    logic is_cnt;
    logic fault;
    word_op = (op == OP_LW) || (op == OP_SW);
    half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    in_dm   = (a <= DM_TOP);
    in_tc   = ((a >= TC0_BASE) && (a <= TC0_BASE + 32'd11)) ||
              ((a >= TC1_BASE) && (a <= TC1_BASE + 32'd11));
    in_ig   = (a >= IG_BASE) && (a <= IG_BASE + 32'd3);
    is_cnt  = (a[31:2] == TC0_CNT[31:2]) || (a[31:2] == TC1_CNT[31:2]);
    if (word_op && (a[1:0] != 2'b00)) begin
      fault = 1'b1;
    end else if (half_op && a[0]) begin
      fault = 1'b1;
    end else if (!in_dm && !in_tc && !in_ig) begin
      fault = 1'b1;
    end else if ((in_tc || in_ig) && !word_op) begin
      fault = 1'b1;
    end else if ((op == OP_SW) && in_tc && is_cnt) begin
      fault = 1'b1;
    end else if ((op == OP_LW) && in_ig) begin
      fault = 1'b1;
    end else begin
      fault = 1'b0;
    end
    return fault;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane helper: store byte enables / data shift and load extract / extend.
// Purely combinational; used once on the store path and once on the load path.
module lsu_lane
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: byte enables and lane-shifted write data.
  always_comb begin
    byteen     = 4'b0000;
    wdata_lane = 32'h0000_0000;
    case (op)
      OP_SW: begin
        byteen     = 4'b1111;
        wdata_lane = wdata;
      end
      OP_SH: begin
        if (off[1]) begin
          byteen     = 4'b1100;
          wdata_lane = {wdata[15:0], 16'h0000};
        end else begin
          byteen     = 4'b0011;
          wdata_lane = {16'h0000, wdata[15:0]};
        end
      end
      OP_SB: begin
        byteen     = 4'b0001 << off;
        wdata_lane = {24'h00_0000, wdata[7:0]} << {off, 3'b000};
      end
      default: begin
        byteen     = 4'b0000;
        wdata_lane = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed lane, then sign or zero extend.
  always_comb begin
    byte_s    = 8'h00;
    half_s    = 16'h0000;
    rdata_ext = 32'h0000_0000;
    case (off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (op)
      OP_LW:   rdata_ext = rdata;
      OP_LH:   rdata_ext = {{16{half_s[15]}}, half_s};
      OP_LHU:  rdata_ext = {16'h0000, half_s};
      OP_LB:   rdata_ext = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  rdata_ext = {24'h00_0000, byte_s};
      default: rdata_ext = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// M-stage load/store unit: address checks, single-outstanding bus FSM, load result.
// Define LSU_TIMEOUT_EN to add a bus watchdog that raises DBE (code 7).
module mem_lsu
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        Req,
  input  logic        advance,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  lsu_state_e  state_r;
  lsu_state_e  state_s;
  logic        op_act_s;
  logic        addr_exc_s;
  logic        issue_s;
  logic        tmo_hit_s;
  logic        tmo_s;
  logic        tmo_exc_s;

  logic        bus_req_r;
  logic        bus_we_r;
  logic [31:0] bus_addr_r;
  logic [3:0]  bus_be_r;
  logic [31:0] bus_wd_r;
  logic [3:0]  op_r;
  logic [1:0]  off_r;
  logic [31:0] ld_data_r;

  logic [3:0]  st_be_s;
  logic [31:0] st_wd_s;
  logic [31:0] ld_ext_s;
  logic [31:0] unused_st_ext_s;
  logic [3:0]  unused_ld_be_s;
  logic [31:0] unused_ld_wd_s;

  lsu_lane u_store_lane (
    .op         (mem_op),
    .off        (addr[1:0]),
    .wdata      (wdata),
    .rdata      (32'h0000_0000),
    .byteen     (st_be_s),
    .wdata_lane (st_wd_s),
    .rdata_ext  (unused_st_ext_s)
  );

  lsu_lane u_load_lane (
    .op         (op_r),
    .off        (off_r),
    .wdata      (32'h0000_0000),
    .rdata      (bus_rdata),
    .byteen     (unused_ld_be_s),
    .wdata_lane (unused_ld_wd_s),
    .rdata_ext  (ld_ext_s)
  );

  assign op_act_s   = op_valid && (op_is_load(mem_op) || op_is_store(mem_op));
  assign addr_exc_s = op_act_s && addr_fault(mem_op, addr);
  assign issue_s    = (state_r == ST_IDLE) && op_act_s && !addr_exc_s && !Req;

`ifdef LSU_TIMEOUT_EN
  logic [4:0] tmo_cnt_r;
  logic       tmo_exc_r;

  assign tmo_hit_s = ((state_r == ST_BUSY) || (state_r == ST_DRAIN)) && !bus_ack &&
                     (tmo_cnt_r >= (TIMEOUT_CYCLES - 5'd1));
  assign tmo_exc_s = tmo_exc_r;

  // Watchdog counter for an outstanding access; DBE pulse follows a BUSY timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= 5'd0;
      tmo_exc_r <= 1'b0;
    end else begin
      if (((state_r == ST_BUSY) || (state_r == ST_DRAIN)) && !bus_ack && !tmo_hit_s) begin
        tmo_cnt_r <= tmo_cnt_r + 5'd1;
      end else begin
        tmo_cnt_r <= 5'd0;
      end
      tmo_exc_r <= tmo_s;
    end
  end
`else
  logic unused_tmo_s;

  assign tmo_hit_s    = 1'b0;
  assign tmo_exc_s    = 1'b0;
  assign unused_tmo_s = tmo_s;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; tmo_s flags a timeout that must be reported as DBE.
  always_comb begin
    state_s = state_r;
    tmo_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) begin
          state_s = ST_BUSY;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_s = Req ? ST_IDLE : ST_DONE;
        end else if (Req) begin
          state_s = ST_DRAIN;
        end else if (tmo_hit_s) begin
          state_s = ST_IDLE;
          tmo_s   = 1'b1;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (advance || Req) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (bus_ack || tmo_hit_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus request fields latched at issue and held until ack; load result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_req_r  <= 1'b0;
      bus_we_r   <= 1'b0;
      bus_addr_r <= 32'h0000_0000;
      bus_be_r   <= 4'b0000;
      bus_wd_r   <= 32'h0000_0000;
      op_r       <= 4'd0;
      off_r      <= 2'd0;
      ld_data_r  <= 32'h0000_0000;
    end else begin
      if (issue_s) begin
        bus_req_r  <= 1'b1;
        bus_we_r   <= op_is_store(mem_op);
        bus_addr_r <= {addr[31:2], 2'b00};
        bus_be_r   <= st_be_s;
        bus_wd_r   <= st_wd_s;
        op_r       <= mem_op;
        off_r      <= addr[1:0];
      end else if (((state_r == ST_BUSY) || (state_r == ST_DRAIN)) && (bus_ack || tmo_hit_s)) begin
        bus_req_r  <= 1'b0;
      end
      // A flush in the ack cycle discards the result, as does DRAIN.
      if ((state_r == ST_BUSY) && bus_ack && !Req && op_is_load(op_r)) begin
        ld_data_r <= ld_ext_s;
      end
    end
  end

  // Exception report: watchdog DBE takes precedence over address faults.
  always_comb begin
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    if (tmo_exc_s) begin
      exc_valid = 1'b1;
      exc_code  = EXC_DBE;
    end else if (addr_exc_s) begin
      exc_valid = 1'b1;
      exc_code  = op_is_store(mem_op) ? EXC_ADES : EXC_ADEL;
    end else begin
      exc_valid = 1'b0;
      exc_code  = 5'd0;
    end
  end

  assign stall      = op_act_s && !addr_exc_s &&
                      ((state_r == ST_IDLE) || (state_r == ST_BUSY));
  assign bus_req    = bus_req_r;
  assign bus_we     = bus_we_r;
  assign bus_addr   = bus_addr_r;
  assign bus_byteen = bus_be_r;
  assign bus_wdata  = bus_wd_r;
  assign ld_data    = ld_data_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed self-checking bench for mem_lsu with a bus/load-result scoreboard.
module tb_mem_lsu;

  localparam logic [3:0] T_LW = 4'd1, T_LH = 4'd2, T_LHU = 4'd3, T_LB = 4'd4, T_LBU = 4'd5;
  localparam logic [3:0] T_SW = 4'd6, T_SH = 4'd7, T_SB = 4'd8;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } txn_t;

  logic        clk, reset, op_valid, Req, advance, bus_ack;
  logic [3:0]  mem_op;
  logic [31:0] addr, wdata, bus_rdata;
  logic        bus_req, bus_we, stall, exc_valid;
  logic [31:0] bus_addr, bus_wdata, ld_data;
  logic [3:0]  bus_byteen;
  logic [4:0]  exc_code;

  int          passed = 0;
  int          failed = 0;
  int          total  = 0;
  logic [31:0] last_ld = 32'h0;
  txn_t        bus_q[$];
  logic [31:0] ld_q[$];

  mem_lsu dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .mem_op(mem_op), .addr(addr),
    .wdata(wdata), .Req(Req), .advance(advance), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ld_data(ld_data), .stall(stall),
    .exc_valid(exc_valid), .exc_code(exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one mapped access, ack it after ack_wait BUSY cycles, check via scoreboard.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int ack_wait, input logic [31:0] rd,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input logic [31:0] e_ld);
    txn_t t;
    txn_t got;
    int   busy;
    int   stalls;
    bit   acked;
    t.we = (op >= T_SW);
    t.a  = {a[31:2], 2'b00};
    t.be = e_be;
    t.wd = e_wd;
    bus_q.push_back(t);
    if (op >= T_SW) ld_q.push_back(last_ld);
    else begin
      ld_q.push_back(e_ld);
      last_ld = e_ld;
    end
    @(posedge clk); #1;
    op_valid = 1'b1; mem_op = op; addr = a; wdata = wd; bus_ack = 1'b0; advance = 1'b0;
    @(negedge clk);
    stalls = stall ? 1 : 0;
    chk({tag, "_issue_nobus"}, {31'd0, bus_req}, 32'd0);
    busy = 0;
    acked = 1'b0;
    for (int c = 0; c < 40 && !acked; c++) begin
      @(posedge clk); #1;
      if (bus_req) begin
        busy++;
        if (busy == 1) begin
          got = bus_q.pop_front();
          chk({tag, "_we"},   {31'd0, bus_we},     {31'd0, got.we});
          chk({tag, "_addr"}, bus_addr,            got.a);
          chk({tag, "_be"},   {28'd0, bus_byteen}, {28'd0, got.be});
          if (got.we) chk({tag, "_wdata"}, bus_wdata, got.wd);
        end
        if (busy == ack_wait) begin
          bus_ack = 1'b1;
          bus_rdata = rd;
          acked = 1'b1;
        end
      end
      @(negedge clk);
      if (stall) stalls++;
    end
    chk({tag, "_ack_seen"}, {31'd0, acked}, 32'd1);
    if (busy == 0 && bus_q.size() > 0) void'(bus_q.pop_front());
    @(posedge clk); #1;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
    chk({tag, "_done_busreq"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_ld_data"}, ld_data, ld_q.pop_front());
    chk({tag, "_stall_cycles"}, stalls, 1 + ack_wait);
    advance = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; mem_op = 4'd0; advance = 1'b0;
  endtask

  // Present a faulting access for one cycle; it must never reach the bus.
  task automatic exc_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [4:0] code);
    @(posedge clk); #1;
    op_valid = 1'b1; mem_op = op; addr = a; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk({tag, "_exc_valid"}, {31'd0, exc_valid}, 32'd1);
    chk({tag, "_exc_code"},  {27'd0, exc_code},  {27'd0, code});
    chk({tag, "_stall"},     {31'd0, stall},     32'd0);
    @(posedge clk); #1;
    chk({tag, "_no_busreq"}, {31'd0, bus_req}, 32'd0);
    op_valid = 1'b0; mem_op = 4'd0;
  endtask

  initial begin
    reset = 1'b0; op_valid = 1'b0; mem_op = 4'd0; addr = 32'h0; wdata = 32'h0;
    Req = 1'b0; advance = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    #12;
    chk("rst_bus_req",   {31'd0, bus_req},   32'd0);
    chk("rst_ld_data",   ld_data,            32'd0);
    chk("rst_stall",     {31'd0, stall},     32'd0);
    chk("rst_exc_valid", {31'd0, exc_valid}, 32'd0);
    chk("rst_exc_code",  {27'd0, exc_code},  32'd0);
    reset = 1'b1;

    // stray ack in IDLE has no effect
    @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    @(posedge clk); #1; bus_ack = 1'b0;
    chk("idle_ack_busreq", {31'd0, bus_req}, 32'd0);
    chk("idle_ack_ld",     ld_data,          32'd0);

    run_op("lb",  T_LB,  32'h0000_0103, 32'h0,         3, 32'h80FF_1234, 4'b0000, 32'h0,         32'hFFFF_FF80);
    run_op("sh",  T_SH,  32'h0000_0002, 32'h0000_ABCD, 1, 32'h0,         4'b1100, 32'hABCD_0000, 32'h0);
    run_op("sb",  T_SB,  32'h0000_0001, 32'h0000_0055, 2, 32'h0,         4'b0010, 32'h0000_5500, 32'h0);
    run_op("lhu", T_LHU, 32'h0000_2FFE, 32'h0,         1, 32'h8001_0000, 4'b0000, 32'h0,         32'h0000_8001);
    run_op("lh",  T_LH,  32'h0000_0000, 32'h0,         2, 32'h1234_F00F, 4'b0000, 32'h0,         32'hFFFF_F00F);
    run_op("lbu", T_LBU, 32'h0000_0001, 32'h0,         1, 32'h0000_9A00, 4'b0000, 32'h0,         32'h0000_009A);
    run_op("sw_tc0", T_SW, 32'h0000_7F00, 32'h0000_0064, 1, 32'h0,       4'b1111, 32'h0000_0064, 32'h0);
    run_op("lw_tc1", T_LW, 32'h0000_7F18, 32'h0,       1, 32'h0000_0042, 4'b0000, 32'h0,         32'h0000_0042);
    run_op("sw_ig",  T_SW, 32'h0000_7F20, 32'h0000_0001, 1, 32'h0,       4'b1111, 32'h0000_0001, 32'h0);

    exc_op("lw_misal",  T_LW, 32'h0000_0006, 5'd4);
    exc_op("sw_cnt",    T_SW, 32'h0000_7F08, 5'd5);
    exc_op("lh_dev",    T_LH, 32'h0000_7F00, 5'd4);
    exc_op("lw_ig",     T_LW, 32'h0000_7F20, 5'd4);
    exc_op("sb_unmap",  T_SB, 32'h0000_3000, 5'd5);
    exc_op("sh_misal",  T_SH, 32'h0000_0001, 5'd5);

    // flush during a store: store still acked once, next load waits for IDLE
    @(posedge clk); #1;
    op_valid = 1'b1; mem_op = T_SW; addr = 32'h0000_0010; wdata = 32'h1122_3344;
    @(negedge clk); chk("req_issue_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("req_sw_busreq", {31'd0, bus_req}, 32'd1);
    chk("req_sw_wdata",  bus_wdata,        32'h1122_3344);
    Req = 1'b1;
    @(posedge clk); #1;
    Req = 1'b0; mem_op = T_LW; addr = 32'h0000_0020;
    chk("req_drain_busreq", {31'd0, bus_req}, 32'd1);
    chk("req_drain_we",     {31'd0, bus_we},  32'd1);
    bus_ack = 1'b1;
    @(negedge clk); chk("req_drain_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("req_idle_busreq", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    chk("req_ld_unchanged", ld_data, last_ld);
    chk("req_lw_stall",     {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    chk("req_lw_busreq", {31'd0, bus_req}, 32'd1);
    chk("req_lw_we",     {31'd0, bus_we},  32'd0);
    chk("req_lw_addr",   bus_addr,         32'h0000_0020);
    bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("req_lw_ld", ld_data, 32'hCAFE_F00D);
    last_ld = 32'hCAFE_F00D;
    advance = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0; mem_op = 4'd0; advance = 1'b0;

    // asynchronous reset in the middle of BUSY
    @(posedge clk); #1;
    op_valid = 1'b1; mem_op = T_LW; addr = 32'h0000_0040;
    @(posedge clk); #1;
    chk("arst_busy_req", {31'd0, bus_req}, 32'd1);
    #2; reset = 1'b0; #1;
    chk("arst_req_drop", {31'd0, bus_req}, 32'd0);
    chk("arst_ld_clear", ld_data, 32'd0);
    op_valid = 1'b0; mem_op = 4'd0;
    @(negedge clk); reset = 1'b1; last_ld = 32'h0;

`ifdef LSU_TIMEOUT_EN
    begin
      bit seen;
      int cyc;
      seen = 1'b0;
      cyc = 0;
      @(posedge clk); #1;
      op_valid = 1'b1; mem_op = T_LW; addr = 32'h0000_0000;
      for (int c = 1; c < 40 && !seen; c++) begin
        @(posedge clk); #1;
        if (exc_valid) begin
          seen = 1'b1;
          cyc = c;
          op_valid = 1'b0; mem_op = 4'd0;
          chk("tmo_code",   {27'd0, exc_code}, 32'd7);
          chk("tmo_busreq", {31'd0, bus_req},  32'd0);
        end
      end
      chk("tmo_seen",  {31'd0, seen}, 32'd1);
      chk("tmo_cycle", cyc, 17);
      op_valid = 1'b0; mem_op = 4'd0;
      @(posedge clk); #1;
      chk("tmo_pulse", {31'd0, exc_valid}, 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
